// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 8-LED running-light sequencer with debounced mode/speed keys and pause.
// Latency: key press -> mode/speed change after 2 sync + DEB_CYC debounce + 1 event + 1 update cycles;
//          step_tick and the new LED value appear in the same cycle. No backpressure (free-running).
// Optional feature: define LED_PWM_EN to dim the LED outputs with a free-running 8-bit PWM.
module led_pattern_ctrl #(
    parameter int LED_W     = 8,
    parameter int STEP_BASE = 25_000_000,
    parameter int DEB_CYC   = 1_000_000
`ifdef LED_PWM_EN
    ,
    parameter int PWM_DUTY  = 128
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_mode,
    input  logic             key_speed,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic [2:0]       mode,
    output logic [1:0]       speed,
    output logic             step_tick
);

    // Prescaler only ever holds values up to STEP_BASE-1.
    localparam int CNT_W = $clog2(STEP_BASE);
    // Debounce counter must hold DEB_CYC-1; +1 keeps the width >= 1 for tiny DEB_CYC.
    localparam int DB_W  = $clog2(DEB_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEB_CYC - 1);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Key index 0 = mode key, 1 = speed key.
    localparam int K_MODE  = 0;
    localparam int K_SPEED = 1;

    typedef enum logic [2:0] {
        M_LEFT     = 3'd0,
        M_RIGHT    = 3'd1,
        M_PINGPONG = 3'd2,
        M_BLINK    = 3'd3,
        M_FILL     = 3'd4
    } mode_e;

    // ------------------------------------------------------------------
    // Key synchronisation and debouncing
    // ------------------------------------------------------------------
    logic [1:0]      key_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    assign key_raw = {key_speed, key_mode};

    // Debounce: count consecutive samples that disagree with the accepted level;
    // any return to the accepted level restarts the count. A press is the 1->0 acceptance.
    always_comb begin
        stable_d = stable_q;
        press_d  = 2'b00;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                stable_d[i] = sync2_q[i];
                press_d[i]  = ~sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Key registers: two-flop synchroniser, accepted level, count and press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            stable_q <= 2'b11;
            press_q  <= 2'b00;
            db_cnt_q <= '{default: '0};
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pattern state machine, prescaler and speed
    // ------------------------------------------------------------------
    mode_e            mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_m1;
    logic [LED_W-1:0] pat_q, pat_d;
    logic [LED_W-1:0] step_pat;
    logic             step_dir;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    mode_e            mode_next;

    // First pattern shown when a mode is entered.
    function automatic logic [LED_W-1:0] init_pat(input mode_e m);
        logic [LED_W-1:0] p;
        p = '0;
        case (m)
            M_LEFT:     p = LED_W'(1);
            M_RIGHT:    p = {1'b1, {(LED_W-1){1'b0}}};
            M_PINGPONG: p = LED_W'(1);
            default:    p = '0;
        endcase
        return p;
    endfunction

    // Step period minus one: faster speeds halve the base period.
    always_comb begin
        period_m1 = CNT_W'((STEP_BASE >> speed_q) - 1);
    end

    // Mode sequence wraps from FILL back to LEFT.
    always_comb begin
        mode_next = M_LEFT;
        case (mode_q)
            M_LEFT:     mode_next = M_RIGHT;
            M_RIGHT:    mode_next = M_PINGPONG;
            M_PINGPONG: mode_next = M_BLINK;
            M_BLINK:    mode_next = M_FILL;
            default:    mode_next = M_LEFT;
        endcase
    end

    // Per-step pattern transform for the current mode; PINGPONG turns around on an end LED
    // so each end is shown exactly once per pass.
    always_comb begin
        step_pat = pat_q;
        step_dir = dir_q;
        case (mode_q)
            M_LEFT:  step_pat = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            M_RIGHT: step_pat = {pat_q[0], pat_q[LED_W-1:1]};
            M_PINGPONG: begin
                if (dir_q == DIR_LEFT) begin
                    if (pat_q[LED_W-1]) begin
                        step_pat = pat_q >> 1;
                        step_dir = DIR_RIGHT;
                    end else begin
                        step_pat = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        step_pat = pat_q << 1;
                        step_dir = DIR_LEFT;
                    end else begin
                        step_pat = pat_q >> 1;
                    end
                end
            end
            M_BLINK: step_pat = ~pat_q;
            M_FILL:  step_pat = (&pat_q) ? '0 : {pat_q[LED_W-2:0], 1'b1};
            default: step_pat = LED_W'(1);
        endcase
    end

    // Next state: key events override (and swallow) a same-cycle step; pause freezes the prescaler.
    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        if (press_q[K_MODE] || press_q[K_SPEED]) begin
            cnt_d = '0;
            if (press_q[K_SPEED]) begin
                speed_d = speed_q + 2'd1;
            end
            if (press_q[K_MODE]) begin
                mode_d = mode_next;
                pat_d  = init_pat(mode_next);
                dir_d  = DIR_LEFT;
            end
        end else if (!pause) begin
            if (cnt_q == period_m1) begin
                cnt_d  = '0;
                pat_d  = step_pat;
                dir_d  = step_dir;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pattern, mode, speed and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= M_LEFT;
            speed_q <= 2'd0;
            cnt_q   <= '0;
            pat_q   <= LED_W'(1);
            dir_q   <= DIR_LEFT;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
        end
    end

    assign mode      = mode_q;
    assign speed     = speed_q;
    assign step_tick = tick_q;

    // ------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------
`ifdef LED_PWM_EN
    localparam logic [8:0] DUTY = 9'(PWM_DUTY);

    logic [7:0] pwm_cnt_q, pwm_cnt_d;

    // Free-running PWM phase counter.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
    end

    // PWM phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign led = pat_q & {LED_W{({1'b0, pwm_cnt_q} < DUTY)}};
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with STEP_BASE=16, DEB_CYC=4, LED_W=8.
// A cycle-level reference model derives expected outputs from mode / step count arithmetic.
// Directed phases followed by a randomized phase; every cycle is compared.
module tb_led_pattern_ctrl;

    localparam int LED_W     = 8;
    localparam int STEP_BASE = 16;
    localparam int DEB_CYC   = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_mode  = 1'b1;
    logic       key_speed = 1'b1;
    logic       pause     = 1'b0;
    logic [7:0] led;
    logic [2:0] mode;
    logic [1:0] speed;
    logic       step_tick;

    int    checks   = 0;
    int    failures = 0;
    int    dut_ticks = 0;
    string phase = "reset";

    led_pattern_ctrl #(
        .LED_W    (LED_W),
        .STEP_BASE(STEP_BASE),
        .DEB_CYC  (DEB_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_speed(key_speed),
        .pause    (pause),
        .led      (led),
        .mode     (mode),
        .speed    (speed),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_mode, m_speed, m_k, m_cnt, m_period;
    bit m_tick;
    bit m_s1[2], m_s2[2], m_stable[2], m_evt[2], m_new[2], m_raw[2];
    int m_run[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_speed = 0; m_k = 0; m_cnt = 0; m_tick = 0;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1; m_s2[i] = 1; m_stable[i] = 1; m_evt[i] = 0; m_run[i] = 0;
            end
        end else begin
            m_raw[0] = key_mode;
            m_raw[1] = key_speed;
            m_period = STEP_BASE >> m_speed;
            if (m_evt[0] || m_evt[1]) begin
                m_tick = 0;
                m_cnt  = 0;
                if (m_evt[0]) begin m_mode = (m_mode + 1) % 5; m_k = 0; end
                if (m_evt[1]) m_speed = (m_speed + 1) % 4;
            end else if (!pause && m_cnt == m_period - 1) begin
                m_cnt = 0; m_k++; m_tick = 1;
            end else begin
                if (!pause) m_cnt++;
                m_tick = 0;
            end
            for (int i = 0; i < 2; i++) begin
                m_new[i] = 0;
                if (m_s2[i] == m_stable[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DEB_CYC) begin
                        m_stable[i] = m_s2[i];
                        m_run[i]    = 0;
                        m_new[i]    = !m_s2[i];
                    end
                end
                m_s2[i]  = m_s1[i];
                m_s1[i]  = m_raw[i];
                m_evt[i] = m_new[i];
            end
        end
    end

    // LED image after k steps in a given mode.
    function automatic logic [7:0] exp_led(input int md, input int k);
        int p;
        case (md)
            0: return 8'(1 << (k % 8));
            1: return 8'(128 >> (k % 8));
            2: begin p = k % 14; return 8'(1 << ((p < 8) ? p : 14 - p)); end
            3: return (k % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'((1 << (k % 9)) - 1);
        endcase
    endfunction

    task automatic check_all();
        logic [7:0] e_led;
        e_led = exp_led(m_mode, m_k);
        checks++;
        assert (led === e_led) else begin
            failures++; $error("FAIL %s led got %h exp %h", phase, led, e_led);
        end
        checks++;
        assert (mode === 3'(m_mode)) else begin
            failures++; $error("FAIL %s mode got %0d exp %0d", phase, mode, m_mode);
        end
        checks++;
        assert (speed === 2'(m_speed)) else begin
            failures++; $error("FAIL %s speed got %0d exp %0d", phase, speed, m_speed);
        end
        checks++;
        assert (step_tick === m_tick) else begin
            failures++; $error("FAIL %s step_tick got %b exp %b", phase, step_tick, m_tick);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (step_tick === 1'b1) dut_ticks++;
            check_all();
        end
    endtask

    task automatic press(input int key, input int hold);
        if (key == 0) key_mode = 1'b0; else key_speed = 1'b0;
        run(hold);
        key_mode  = 1'b1;
        key_speed = 1'b1;
        run(DEB_CYC + 6);
    endtask

    task automatic expect_val(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            failures++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    int t0;

    initial begin
        // 1: reset, then free-running LEFT
        run(3);
        expect_val("reset_led", int'(led), 1);
        expect_val("reset_mode", int'(mode), 0);
        expect_val("reset_tick", int'(step_tick), 0);
        rst_n = 1'b1;
        phase = "left";
        run(128);
        expect_val("left_wrap_led", int'(led), 1);

        // 2: short press ignored, long press accepted
        phase = "debounce";
        press(0, 3);
        expect_val("short_press_mode", int'(mode), 0);
        press(0, 10);
        expect_val("long_press_mode", int'(mode), 1);
        phase = "right";
        run(40);

        // 3: speed cycling and tick period
        phase = "speed";
        press(1, 6); press(1, 6); press(1, 6);
        expect_val("speed3", int'(speed), 3);
        t0 = dut_ticks; run(20);
        expect_val("period2_ticks", dut_ticks - t0, 10);
        press(1, 6);
        expect_val("speed_wrap", int'(speed), 0);
        t0 = dut_ticks; run(32);
        expect_val("period16_ticks", dut_ticks - t0, 2);

        // 4: PINGPONG, BLINK, FILL
        phase = "pingpong"; press(0, 6); run(16 * 15);
        phase = "blink";    press(0, 6); run(40);
        phase = "fill";     press(0, 6); run(16 * 10);

        // 5: pause freezes everything; mode press still lands
        phase = "pause";
        pause = 1'b1;
        t0 = dut_ticks; run(50);
        expect_val("pause_no_ticks", dut_ticks - t0, 0);
        press(0, 6);
        expect_val("pause_mode_led", int'(led), 1);
        expect_val("pause_mode", int'(mode), 0);
        pause = 1'b0;
        run(40);

        // 6: mode event lands on the cycle the prescaler would wrap
        phase = "collide";
        for (int i = 0; i < 40 && m_cnt != 9; i++) run(1);
        expect_val("collide_align", m_cnt, 9);
        key_mode = 1'b0;
        run(7);
        expect_val("collide_tick", int'(step_tick), 0);
        expect_val("collide_led", int'(led), 8'h80);
        expect_val("collide_mode", int'(mode), 1);
        key_mode = 1'b1;
        run(DEB_CYC + 6);

        // randomized keys, bounce, pause
        phase = "random";
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: press(0, int'($urandom_range(1, 8)));
                1: press(1, int'($urandom_range(1, 8)));
                2: begin pause = ~pause; run(int'($urandom_range(3, 30))); end
                3: begin
                    for (int b = 0; b < 6; b++) begin
                        key_mode = 1'($urandom_range(0, 1));
                        run(int'($urandom_range(1, 3)));
                    end
                    key_mode = 1'b1;
                    run(DEB_CYC + 6);
                end
                default: run(int'($urandom_range(5, 40)));
            endcase
        end
        pause = 1'b0;
        run(30);

        // 7: asynchronous reset mid-pattern
        phase = "async_reset";
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_val("arst_led", int'(led), 1);
        expect_val("arst_mode", int'(mode), 0);
        expect_val("arst_speed", int'(speed), 0);
        expect_val("arst_tick", int'(step_tick), 0);
        run(2);
        rst_n = 1'b1;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
